pipe_stage_acc_scale: RTL and testbench



---
 rtl/pipe_stage_pkg.sv | 47 ++++
 rtl/vpe_mac_lane.sv | 82 ++++++++
 rtl/pipe_stage_acc_scale.sv | 133 +++++++++++++
 tb/tb_pipe_stage_acc_scale.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared types, defaults and arithmetic helper for pipe_stage_acc_scale
package pipe_stage_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LANES = 3;
    localparam int DEF_TILE  = 128;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_SAT   = 0;

    // Width of the signed intermediates; wide enough that products and tile sums never overflow before fitting.
    localparam int CALC_W = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_REDUCE,
        S_OUT
    } state_t;

    // Bring a wide signed value back into a w-bit signed range: wrap keeps the low w bits, sat clamps.
    function automatic logic signed [CALC_W-1:0] fit_width(
        input logic signed [CALC_W-1:0] v,
        input int                       w,
        input logic                     sat
    );
        logic signed [CALC_W-1:0] one;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        logic signed [CALC_W-1:0] r;
        one = {{(CALC_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (sat) begin
            if (v > hi) begin
                r = hi;
            end else if (v < lo) begin
                r = lo;
            end else begin
                r = v;
            end
        end else begin
            r = (v <<< (CALC_W - w)) >>> (CALC_W - w);
        end
        return r;
    endfunction

endpackage

// File: rtl/vpe_mac_lane.sv
// rtl/vpe_mac_lane.sv - one lane of TILE multiply-accumulate registers with reduce and scale
module vpe_mac_lane
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TILE  = DEF_TILE,
    parameter int SAT   = DEF_SAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  acc_en,
    input  logic                  reduce_en,
    input  logic [WIDTH-1:0]      scale,
    input  logic [TILE*WIDTH-1:0] opa,
    input  logic [TILE*WIDTH-1:0] opb,
    output logic [TILE*WIDTH-1:0] acc,
    output logic [WIDTH-1:0]      scal
);

    localparam logic SAT_EN = (SAT != 0);

    logic [WIDTH-1:0]         acc_q [TILE];
    logic [WIDTH-1:0]         acc_d [TILE];
    logic [WIDTH-1:0]         scal_q;
    logic [WIDTH-1:0]         scal_d;
    logic signed [CALC_W-1:0] lane_sum;
    logic signed [CALC_W-1:0] sum_fit;

    function automatic logic signed [CALC_W-1:0] sext(input logic [WIDTH-1:0] x);
        return {{(CALC_W-WIDTH){x[WIDTH-1]}}, x};
    endfunction

    // Elementwise next accumulator value: full-precision product plus old value, then wrap or clamp.
    always_comb begin
        for (int t = 0; t < TILE; t++) begin
            acc_d[t] = WIDTH'(fit_width(sext(acc_q[t]) +
                                        sext(opa[t*WIDTH +: WIDTH]) * sext(opb[t*WIDTH +: WIDTH]),
                                        WIDTH, SAT_EN));
        end
    end

    // Lane reduction over the tile, fitted, then multiplied by the latched scale and fitted again.
    always_comb begin
        lane_sum = '0;
        for (int t = 0; t < TILE; t++) begin
            lane_sum = lane_sum + sext(acc_q[t]);
        end
        sum_fit = fit_width(lane_sum, WIDTH, SAT_EN);
        scal_d  = WIDTH'(fit_width(sum_fit * sext(scale), WIDTH, SAT_EN));
    end

    // Accumulator and scaled-result registers; clear only happens at a job start, never with acc_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < TILE; t++) begin
                acc_q[t] <= '0;
            end
            scal_q <= '0;
        end else begin
            if (clear) begin
                for (int t = 0; t < TILE; t++) begin
                    acc_q[t] <= '0;
                end
            end else if (acc_en) begin
                for (int t = 0; t < TILE; t++) begin
                    acc_q[t] <= acc_d[t];
                end
            end
            if (reduce_en) begin
                scal_q <= scal_d;
            end
        end
    end

    for (genvar g = 0; g < TILE; g++) begin : g_acc_out
        assign acc[g*WIDTH +: WIDTH] = acc_q[g];
    end

    assign scal = scal_q;

endmodule

// File: rtl/pipe_stage_acc_scale.sv
// rtl/pipe_stage_acc_scale.sv - multi-lane vector MAC stage with per-lane reduction and scaling
module pipe_stage_acc_scale
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int TILE  = DEF_TILE,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SAT   = DEF_SAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [CNT_W-1:0]            num_beats_i,
    input  logic                        mode_i,
    input  logic [LANES*WIDTH-1:0]      scale_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [LANES*TILE*WIDTH-1:0] opa_i,
    input  logic [LANES*TILE*WIDTH-1:0] opb_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANES*TILE*WIDTH-1:0] acc_o,
    output logic [LANES*WIDTH-1:0]      scal_o,
    output logic                        busy_o,
    output logic                        finished_o,
    output logic [CNT_W-1:0]            beat_cnt_o
);

    localparam int LANE_W = TILE * WIDTH;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic [CNT_W-1:0]     num_beats_q;
    logic [LANES*WIDTH-1:0] scale_q;
    logic                 finished_q;
    logic                 start_fire;
    logic                 beat_fire;
    logic                 reduce_en;
    logic                 out_fire;
    logic                 clear_acc;

    // Next-state and handshake decode; every strobe defaults low.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        start_fire  = 1'b0;
        beat_fire   = 1'b0;
        reduce_en   = 1'b0;
        out_fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && (num_beats_i != '0)) begin
                    start_fire = 1'b1;
                    state_d    = S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    beat_fire = 1'b1;
                    if ((beat_cnt_q + CNT_W'(1)) == num_beats_q) begin
                        state_d = S_REDUCE;
                    end
                end
            end
            S_REDUCE: begin
                reduce_en = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    out_fire = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, beat counter, latched job configuration and the post-handshake pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            num_beats_q <= '0;
            scale_q     <= '0;
            finished_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            finished_q <= out_fire;
            if (start_fire) begin
                num_beats_q <= num_beats_i;
                scale_q     <= scale_i;
                beat_cnt_q  <= '0;
            end else if (beat_fire) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
        end
    end

    // Mode only matters at the start edge, so it drives the clear directly instead of being stored.
    assign clear_acc = start_fire && !mode_i;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vpe_mac_lane #(
            .WIDTH (WIDTH),
            .TILE  (TILE),
            .SAT   (SAT)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear_acc),
            .acc_en    (beat_fire),
            .reduce_en (reduce_en),
            .scale     (scale_q[l*WIDTH +: WIDTH]),
            .opa       (opa_i[l*LANE_W +: LANE_W]),
            .opb       (opb_i[l*LANE_W +: LANE_W]),
            .acc       (acc_o[l*LANE_W +: LANE_W]),
            .scal      (scal_o[l*WIDTH +: WIDTH])
        );
    end

    assign busy_o     = (state_q != S_IDLE);
    assign finished_o = finished_q;
    assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_pipe_stage_acc_scale.sv
// tb/tb_pipe_stage_acc_scale.sv - self-checking bench for pipe_stage_acc_scale (wrap and sat builds)
module tb_pipe_stage_acc_scale;

    localparam int W    = 16;
    localparam int L    = 2;
    localparam int T    = 4;
    localparam int CW   = 8;
    localparam int MAXN = 8;
    localparam int AW   = L * T * W;
    localparam int SW   = L * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [CW-1:0] num_beats_i;
    logic          mode_i;
    logic [SW-1:0] scale_i;
    logic          in_valid_i;
    logic [AW-1:0] opa_i;
    logic [AW-1:0] opb_i;
    logic          out_ready_i;

    logic          in_ready_w, out_valid_w, busy_w, finished_w;
    logic [AW-1:0] acc_w;
    logic [SW-1:0] scal_w;
    logic [CW-1:0] beat_cnt_w;
    logic          in_ready_s, out_valid_s, busy_s, finished_s;
    logic [AW-1:0] acc_s;
    logic [SW-1:0] scal_s;
    logic [CW-1:0] beat_cnt_s;

    always #5 clk = ~clk;

    pipe_stage_acc_scale #(.WIDTH(W), .LANES(L), .TILE(T), .CNT_W(CW), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .start_i(start_i), .num_beats_i(num_beats_i), .mode_i(mode_i),
        .scale_i(scale_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_w), .opa_i(opa_i),
        .opb_i(opb_i), .out_valid_o(out_valid_w), .out_ready_i(out_ready_i), .acc_o(acc_w),
        .scal_o(scal_w), .busy_o(busy_w), .finished_o(finished_w), .beat_cnt_o(beat_cnt_w)
    );

    pipe_stage_acc_scale #(.WIDTH(W), .LANES(L), .TILE(T), .CNT_W(CW), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .start_i(start_i), .num_beats_i(num_beats_i), .mode_i(mode_i),
        .scale_i(scale_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_s), .opa_i(opa_i),
        .opb_i(opb_i), .out_valid_o(out_valid_s), .out_ready_i(out_ready_i), .acc_o(acc_s),
        .scal_o(scal_s), .busy_o(busy_s), .finished_o(finished_s), .beat_cnt_o(beat_cnt_s)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference state, index 0 = wrap build, 1 = saturating build
    longint m_acc [2][L][T];
    longint m_scal [2][L];
    longint op_a [MAXN][L][T];
    longint op_b [MAXN][L][T];
    longint sc [L];
    int     gap [MAXN];
    logic [AW-1:0] exp_acc [2];
    logic [SW-1:0] exp_scal [2];

    typedef struct {
        bit mode;
        int n;
        int a;
        int b;
        int scl;
        int gp;
        int stall;
        int acc_wr;
        int scal_wr;
        int acc_sat;
        int scal_sat;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic longint fit(input longint v, input int s);
        longint m;
        if (s != 0) begin
            if (v > 32767) return 32767;
            if (v < -32768) return -32768;
            return v;
        end
        m = v % 65536;
        if (m < 0) m = m + 65536;
        if (m >= 32768) m = m - 65536;
        return m;
    endfunction

    function automatic longint rnd16();
        int unsigned r;
        r = $urandom_range(0, 65535);
        return longint'(r) - ((r >= 32768) ? 65536 : 0);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++)
            for (int l = 0; l < L; l++) begin
                m_scal[s][l] = 0;
                for (int t = 0; t < T; t++) m_acc[s][l][t] = 0;
            end
    endtask

    task automatic model_job(input bit mode, input int n);
        longint sum;
        for (int s = 0; s < 2; s++) begin
            for (int l = 0; l < L; l++) begin
                for (int t = 0; t < T; t++) begin
                    if (!mode) m_acc[s][l][t] = 0;
                    for (int b = 0; b < n; b++)
                        m_acc[s][l][t] = fit(m_acc[s][l][t] + op_a[b][l][t] * op_b[b][l][t], s);
                end
                sum = 0;
                for (int t = 0; t < T; t++) sum = sum + m_acc[s][l][t];
                m_scal[s][l] = fit(fit(sum, s) * sc[l], s);
            end
        end
    endtask

    task automatic exp_from_model();
        for (int s = 0; s < 2; s++)
            for (int l = 0; l < L; l++) begin
                exp_scal[s][l*W +: W] = W'(m_scal[s][l]);
                for (int t = 0; t < T; t++) exp_acc[s][(l*T+t)*W +: W] = W'(m_acc[s][l][t]);
            end
    endtask

    // Called and returns just after a falling edge; the next job may start in the finished cycle.
    task automatic run_job(input bit mode, input int n, input int stall, input string tag);
        int cyc;
        int gsum;
        int guard;
        start_i     = 1'b1;
        num_beats_i = CW'(n);
        mode_i      = mode;
        for (int l = 0; l < L; l++) scale_i[l*W +: W] = W'(sc[l]);
        cyc  = 0;
        gsum = 0;
        @(negedge clk); cyc++;
        start_i = 1'b0;
        chk({tag, " ready"}, AW'({in_ready_w, in_ready_s, busy_w, busy_s, finished_w, finished_s}),
            AW'(6'b111100));
        for (int b = 0; b < n; b++) begin
            for (int g = 0; g < gap[b]; g++) begin
                in_valid_i = 1'b0;
                @(negedge clk); cyc++;
            end
            gsum = gsum + gap[b];
            for (int l = 0; l < L; l++)
                for (int t = 0; t < T; t++) begin
                    opa_i[(l*T+t)*W +: W] = W'(op_a[b][l][t]);
                    opb_i[(l*T+t)*W +: W] = W'(op_b[b][l][t]);
                end
            in_valid_i = 1'b1;
            @(negedge clk); cyc++;
        end
        in_valid_i = 1'b0;
        guard = 0;
        while (!out_valid_w && guard < 20) begin
            @(negedge clk); cyc++; guard++;
        end
        chk({tag, " latency"}, AW'(cyc), AW'(n + 2 + gsum));
        chk({tag, " outvalid"}, AW'({out_valid_w, out_valid_s, in_ready_w, in_ready_s}), AW'(4'b1100));
        chk({tag, " acc_wrap"}, acc_w, exp_acc[0]);
        chk({tag, " acc_sat"}, acc_s, exp_acc[1]);
        chk({tag, " scal"}, AW'({scal_w, scal_s}), AW'({exp_scal[0], exp_scal[1]}));
        for (int i = 0; i < stall; i++) begin
            out_ready_i = 1'b0;
            @(negedge clk);
            chk({tag, " stall ctl"}, AW'({out_valid_w, out_valid_s, finished_w, finished_s}), AW'(4'b1100));
            chk({tag, " stall acc"}, acc_w ^ acc_s, exp_acc[0] ^ exp_acc[1]);
            chk({tag, " stall scal"}, AW'({scal_w, scal_s}), AW'({exp_scal[0], exp_scal[1]}));
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk({tag, " done"}, AW'({finished_w, finished_s, busy_w, busy_s, out_valid_w, out_valid_s}),
            AW'(6'b110000));
        chk({tag, " beats"}, AW'({beat_cnt_w, beat_cnt_s}), AW'({CW'(n), CW'(n)}));
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 2, 3, 4, 2, 0, 0, 24, 192, 24, 192};
        tbl[1] = '{0, 2, 3, 4, 2, 2, 5, 24, 192, 24, 192};
        tbl[2] = '{1, 1, 1, 1, 1, 0, 0, 25, 100, 25, 100};
        tbl[3] = '{0, 2, 32767, 32767, 1, 0, 1, 2, 8, 32767, 32767};
        tbl[4] = '{0, 3, -5, 7, -3, 1, 0, -105, 1260, -105, 1260};
        tbl[5] = '{0, 1, -32768, -32768, 1, 0, 2, 0, 0, 32767, 32767};
        tbl[6] = '{1, 1, -32768, 32767, 2, 0, 0, -32768, 0, -32768, -32768};

        rst = 1'b1; start_i = 1'b0; num_beats_i = '0; mode_i = 1'b0; scale_i = '0;
        in_valid_i = 1'b0; opa_i = '0; opb_i = '0; out_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset ctl", AW'({in_ready_w, out_valid_w, busy_w, finished_w, beat_cnt_w,
                              in_ready_s, out_valid_s, busy_s, finished_s, beat_cnt_s}), '0);
        chk("reset data", acc_w | acc_s | AW'({scal_w, scal_s}), '0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            for (int b = 0; b < MAXN; b++) begin
                gap[b] = (b == 0) ? 0 : tbl[v].gp;
                for (int l = 0; l < L; l++)
                    for (int t = 0; t < T; t++) begin
                        op_a[b][l][t] = tbl[v].a;
                        op_b[b][l][t] = tbl[v].b;
                    end
            end
            for (int l = 0; l < L; l++) sc[l] = tbl[v].scl;
            model_job(tbl[v].mode, tbl[v].n);
            exp_acc[0]  = {(L*T){W'(tbl[v].acc_wr)}};
            exp_acc[1]  = {(L*T){W'(tbl[v].acc_sat)}};
            exp_scal[0] = {L{W'(tbl[v].scal_wr)}};
            exp_scal[1] = {L{W'(tbl[v].scal_sat)}};
            run_job(tbl[v].mode, tbl[v].n, tbl[v].stall, $sformatf("tbl%0d", v));
        end

        // start while accumulating must be ignored, then reset mid-job clears everything
        start_i = 1'b1; num_beats_i = 8'd3; mode_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        opa_i = {(L*T){16'h0005}}; opb_i = {(L*T){16'h0006}};
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        start_i = 1'b1; num_beats_i = 8'd1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start in accum", AW'({beat_cnt_w, beat_cnt_s, busy_w, busy_s, in_ready_w, in_ready_s}),
            AW'({8'd1, 8'd1, 4'b1111}));
        chk("acc one beat", acc_w, {(L*T){16'd30}});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midjob reset ctl", AW'({in_ready_w, out_valid_w, busy_w, finished_w, beat_cnt_w,
                                     in_ready_s, out_valid_s, busy_s, finished_s, beat_cnt_s}), '0);
        chk("midjob reset data", acc_w | acc_s | AW'({scal_w, scal_s}), '0);

        // beats offered while idle are not accepted
        opa_i = {(L*T){16'h0003}}; opb_i = {(L*T){16'h0003}};
        in_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        in_valid_i = 1'b0;
        chk("idle beat ignored", acc_w | acc_s, '0);

        // zero-length start is ignored
        start_i = 1'b1; num_beats_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        chk("zero beats", AW'({busy_w, busy_s, in_ready_w, in_ready_s}), '0);

        for (int j = 0; j < 30; j++) begin
            bit md;
            int n;
            int st;
            md = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 4);
            st = $urandom_range(0, 3);
            for (int b = 0; b < MAXN; b++) begin
                gap[b] = $urandom_range(0, 2);
                for (int l = 0; l < L; l++)
                    for (int t = 0; t < T; t++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            op_a[b][l][t] = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
                            op_b[b][l][t] = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
                        end else begin
                            op_a[b][l][t] = rnd16();
                            op_b[b][l][t] = rnd16();
                        end
                    end
            end
            for (int l = 0; l < L; l++)
                sc[l] = ($urandom_range(0, 1) != 0) ? rnd16() : longint'($urandom_range(0, 7)) - 3;
            model_job(md, n);
            exp_from_model();
            run_job(md, n, st, $sformatf("rnd%0d", j));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
